// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module : fetch_unit_pkg
// Brief  : Shared instruction-field layout, opcode constants and fetch FSM
//          state encoding for the fetch unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int IMMF_BIT = 11;
  localparam int RD_MSB   = 10;
  localparam int RD_LSB   = 8;
  localparam int RS1_MSB  = 7;
  localparam int RS1_LSB  = 5;
  localparam int RS2_MSB  = 4;
  localparam int RS2_LSB  = 2;
  localparam int IMM_MSB  = 4;
  localparam int IMM_LSB  = 0;

  localparam logic [3:0] OPC_BRANCH = 4'b1100;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  function automatic logic is_branch_op(input logic [15:0] ins);
    return ins[OPC_MSB:OPC_LSB] == OPC_BRANCH;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_instr_fifo.sv
// ============================================================================
// Module : instr_fifo
// Brief  : Instruction queue holding {instruction, pc} pairs with push, pop,
//          flush and an occupancy count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic [W-1:0]               i_pc,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [W-1:0]               o_data,
  output logic [W-1:0]               o_pc,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_data [DEPTH];
  logic [W-1:0]  r_pc   [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  // Storage needs no reset: the head is only observed while the count is non-zero.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_data[r_wptr] <= i_data;
      r_pc[r_wptr]   <= i_pc;
    end
  end

  assign o_data  = r_data[r_rptr];
  assign o_pc    = r_pc[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// Brief  : Instruction fetch with prefetch queue, branch redirect and flush.
//          Optional predecode of branch opcodes when FETCH_PREDECODE_EN is set.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        is_branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] pc_out,
  output logic        instr_is_branch
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [15:0]   r_fetch_pc;
  logic          r_inflight;
  logic [15:0]   r_inflight_pc;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [AW:0]   w_count;
  logic [CW-1:0] w_occupancy;
  logic [15:0]   w_head_data;
  logic [15:0]   w_head_pc;

  assign w_occupancy = {1'b0, w_count} + {{(CW-1){1'b0}}, r_inflight};
  assign w_push      = r_inflight && !is_branch_taken;
  assign w_pop       = instr_valid && !stall && !is_branch_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  w_next_state = ST_FETCH;
      ST_FETCH: w_next_state = is_branch_taken ? ST_FLUSH : ST_FETCH;
      ST_FLUSH: w_next_state = is_branch_taken ? ST_FLUSH : ST_FETCH;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    if (r_state == ST_FETCH) imem_req = (w_occupancy < C_DEPTH);
    if (r_state != ST_FLUSH) instr_valid = !w_empty;
  end

  // A redirect clears the in-flight flag so the stale response is never pushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_PC;
    end else begin
      r_inflight <= imem_req && !is_branch_taken;
      if (imem_req) r_inflight_pc <= r_fetch_pc;
      if (is_branch_taken) r_fetch_pc <= branch_target;
      else if (imem_req)   r_fetch_pc <= r_fetch_pc + 16'd1;
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (16)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  (imem_rdata),
    .i_pc    (r_inflight_pc),
    .i_pop   (w_pop),
    .i_flush (is_branch_taken),
    .o_data  (w_head_data),
    .o_pc    (w_head_pc),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign imem_addr = r_fetch_pc;
  assign instr     = w_empty ? 16'h0000 : w_head_data;
  assign pc_out    = w_empty ? 16'h0000 : w_head_pc;

`ifdef FETCH_PREDECODE_EN
  assign instr_is_branch = instr_valid && is_branch_op(instr);
`else
  assign instr_is_branch = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4: instruction-queue entries; power of two, 2..8.
REQ-003 SHALL have ports: clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: stall  in  1  decode cannot accept this cycle.
REQ-006 SHALL have ports: is_branch_taken  in  1  redirect request, one-cycle pulse.
REQ-007 SHALL have ports: branch_target  in  16  redirect address, sampled when is_branch_taken=1.
REQ-008 SHALL have ports: imem_req  out  1  instruction-memory read strobe.
REQ-009 SHALL have ports: imem_addr  out  16  word address for imem_req.
REQ-010 SHALL have ports: imem_rdata  in  16  read data, valid exactly one cycle after imem_req.
REQ-011 SHALL have ports: instr  out  16  queue-head instruction to decode.
REQ-012 SHALL have ports: instr_valid  out  1  instr holds a live instruction.
REQ-013 SHALL have ports: pc_out  out  16  address of instr.
REQ-014 SHALL have ports: instr_is_branch  out  1  predecode flag (see Configuration).

Function
REQ-015 FSM SHALL have states IDLE, FETCH, FLUSH; IDLE->FETCH unconditionally one cycle after reset release.
REQ-016 In FETCH, imem_req SHALL be 1 iff (queue count + in-flight) < DEPTH; imem_addr = fetch PC; fetch PC += 1 per request.
REQ-017 Fetch PC SHALL wrap 16'hFFFF -> 16'h0000 without error.
REQ-018 A response SHALL be written into the queue at the edge after the cycle it is valid on imem_rdata, tagged with its address.
REQ-019 instr/pc_out SHALL be driven combinationally from the queue head; instr_valid = queue not empty and state != FLUSH.
REQ-020 Head entry SHALL be popped on an edge where instr_valid=1 and stall=0; order strictly preserved.
REQ-021 While stall=1, instr and pc_out SHALL hold stable and fetching SHALL continue until the queue is full.
REQ-022 is_branch_taken=1 SHALL, at that edge: clear the queue, set fetch PC to branch_target, mark any in-flight response as dropped, enter FLUSH.
REQ-023 FLUSH SHALL last exactly one cycle with imem_req=0, instr_valid=0; a dropped response SHALL never enter the queue; then FETCH.
REQ-024 is_branch_taken SHALL take priority over stall and over a same-cycle pop or push.
REQ-025 is_branch_taken during FLUSH SHALL restart redirection with the newer target.
REQ-026 Simultaneous push and pop with queue full SHALL not occur (REQ-016); with queue empty, the pushed entry appears the following cycle.

Reset
REQ-027 On reset=0 (asynchronous): state=IDLE, fetch PC=RESET_PC, queue empty, in-flight cleared.
REQ-028 During and one cycle after reset: imem_req=0, imem_addr=RESET_PC, instr=16'h0000, instr_valid=0, pc_out=16'h0000, instr_is_branch=0.
REQ-029 Reset asserted mid-transaction SHALL discard any outstanding response; no stale instruction after release.

Configuration
REQ-030 Macro FETCH_PREDECODE_EN defined: instr_is_branch = instr_valid and instr[15:12]==4'b1100.
REQ-031 Macro FETCH_PREDECODE_EN undefined: instr_is_branch tied to 0, no predecode logic; port list unchanged.

Structure
REQ-032 Shared package SHALL hold: instruction field positions (opcode [15:12], imm flag [11], rd [10:8], rs1 [7:5], rs2 [4:2], imm [4:0]), OPC_BRANCH=4'b1100, FSM state encoding.
REQ-033 Queue SHALL be a sub-module instr_fifo (data+pc per entry, push/pop/flush, count output).

Verification
REQ-034 Reset release, mem[0]=16'h1A23 -> third cycle after release: instr=16'h1A23, pc_out=16'h0000, instr_valid=1.
REQ-035 stall held 10 cycles from first valid -> exactly DEPTH=4 requests then imem_req=0; instr stable; release -> pc_out 0,1,2,3 in order.
REQ-036 Branch to 16'h0040 with stall=1 and one response in flight -> next valid instr has pc_out=16'h0040; dropped word never appears.
REQ-037 RESET_PC=16'hFFFE, no stall -> pc_out sequence FFFE, FFFF, 0000, 0001.
REQ-038 Macro defined, mem[0]=16'hC805 -> instr_is_branch=1 with instr; macro undefined, same stimulus -> 0.
REQ-039 reset=0 asserted one cycle after imem_req -> all outputs at reset values immediately; after release first instr from RESET_PC.
